div_unit: RTL and testbench

- Iterative 32-bit integer divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits between the register file read ports (operands) and the writeback path (result plus destination register tag, later written through the register file write port).
- Restoring radix-2 algorithm, one quotient bit per cycle.
- Valid/ready handshake on both sides, plus a pipeline flush input.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3[1:0]: bit 1 selects remainder, bit 0 selects unsigned.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/div_unit_if.sv
// Request/result handshake bundle between the operand read stage, the divider and writeback.
interface div_unit_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               START;
  logic [1:0]         OP;
  logic [XLEN-1:0]    OPERAND_A;
  logic [XLEN-1:0]    OPERAND_B;
  logic [RADDR_W-1:0] RD_IN;
  logic               FLUSH;
  logic               READY;
  logic               BUSY;
  logic               RESULT_VALID;
  logic               RESULT_READY;
  logic [XLEN-1:0]    RESULT;
  logic [RADDR_W-1:0] RD_OUT;

  modport master (
    output START, OP, OPERAND_A, OPERAND_B, RD_IN, FLUSH, RESULT_READY,
    input  READY, BUSY, RESULT_VALID, RESULT, RD_OUT
  );

  modport slave (
    input  START, OP, OPERAND_A, OPERAND_B, RD_IN, FLUSH, RESULT_READY,
    output READY, BUSY, RESULT_VALID, RESULT, RD_OUT
  );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// divide-by-zero and signed overflow resolved in the accept cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic     CLK,
  input  logic     RST_N,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [RADDR_W-1:0] r_rd;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_quot;
  logic [XLEN-1:0]    r_div;
  logic [XLEN-1:0]    r_result;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_a_abs;
  logic [XLEN-1:0]    w_b_abs;
  logic               w_div0;
  logic               w_ovf;
  logic [XLEN-1:0]    w_special_res;
  logic               w_accept;
  logic [XLEN:0]      w_shift;
  logic [XLEN:0]      w_diff;
  logic               w_qbit;
  logic [XLEN-1:0]    w_rem_nx;
  logic [XLEN-1:0]    w_quot_nx;
  logic [XLEN-1:0]    w_fix_res;
  logic               w_last;

  // Operand conditioning and special-case detection for the accept cycle.
  assign w_signed = ~bus.OP[0];
  assign w_a_neg  = w_signed & bus.OPERAND_A[XLEN-1];
  assign w_b_neg  = w_signed & bus.OPERAND_B[XLEN-1];
  assign w_a_abs  = w_a_neg ? -bus.OPERAND_A : bus.OPERAND_A;
  assign w_b_abs  = w_b_neg ? -bus.OPERAND_B : bus.OPERAND_B;
  assign w_div0   = (bus.OPERAND_B == '0);
  assign w_ovf    = w_signed && (bus.OPERAND_A == INT_MIN) && (bus.OPERAND_B == DIV0_QUOT);
  assign w_accept = (r_state == IDLE) && bus.START && !bus.FLUSH;

  assign w_special_res = w_div0 ? (bus.OP[1] ? bus.OPERAND_A : DIV0_QUOT)
                                : (bus.OP[1] ? '0 : INT_MIN);

  // One restoring step: shift in the next dividend bit and keep the difference if it fits.
  assign w_shift   = {r_rem, r_quot[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_qbit    = ~w_diff[XLEN];
  assign w_rem_nx  = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quot_nx = {r_quot[XLEN-2:0], w_qbit};
  assign w_last    = (r_cnt == CNT_W'(XLEN-1));

  assign w_fix_res = r_op[1] ? (r_neg_r ? -w_rem_nx  : w_rem_nx)
                             : (r_neg_q ? -w_quot_nx : w_quot_nx);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_next     = r_state;
    bus.READY        = 1'b0;
    bus.BUSY         = 1'b0;
    bus.RESULT_VALID = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.READY = 1'b1;
        if (bus.START) w_state_next = (w_div0 || w_ovf) ? DONE : BUSY;
      end
      BUSY: begin
        bus.BUSY = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        bus.RESULT_VALID = 1'b1;
        if (bus.RESULT_READY) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (bus.FLUSH) w_state_next = IDLE;
  end

  // NOTE: datapath registers are plain flops, not a memory, so all of them take the async reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (bus.FLUSH) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op    <= bus.OP;
      r_rd    <= bus.RD_IN;
      r_rem   <= '0;
      r_quot  <= w_a_abs;
      r_div   <= w_b_abs;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_cnt   <= '0;
      if (w_div0 || w_ovf) r_result <= w_special_res;
    end else if (r_state == BUSY) begin
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) r_result <= w_fix_res;
    end
  end

  assign bus.RESULT = r_result;
  assign bus.RD_OUT = r_rd;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, back-pressure, abort paths
// and randomized operations against an arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32), .RADDR_W(5)) dif ();

  div_unit #(.XLEN(32), .RADDR_W(5)) u_dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (dif.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)                                  r = op[1] ? a : 32'hFFFF_FFFF;
    else if (!op[0] && a == INT_MIN && b == '1)      r = op[1] ? 32'd0 : INT_MIN;
    else if (!op[0])                                 r = op[1] ? $signed(a) % $signed(b)
                                                               : $signed(a) / $signed(b);
    else                                             r = op[1] ? a % b : a / b;
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0 || (!op[0] && a == INT_MIN && b == '1)) return 0;
    return 32;
  endfunction

  // Waits for READY, presents the request and returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int k = 0;
    @(negedge clk);
    while (!dif.READY && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!dif.READY) check("ready_timeout", {31'd0, dif.READY}, 32'd1);
    dif.START     = 1'b1;
    dif.OP        = op;
    dif.OPERAND_A = a;
    dif.OPERAND_B = b;
    dif.RD_IN     = rd;
    @(posedge clk);
    #1 dif.START = 1'b0;
  endtask

  // Counts edges after acceptance until RESULT_VALID, sampling on falling edges.
  task automatic wait_valid(output int lat, output bit busy_seen);
    lat = 0;
    busy_seen = 1'b0;
    @(negedge clk);
    while (1) begin
      busy_seen |= dif.BUSY;
      if (dif.RESULT_VALID || lat >= 100) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!dif.RESULT_VALID) check("valid_timeout", {31'd0, dif.RESULT_VALID}, 32'd1);
  endtask

  task automatic release_result();
    dif.RESULT_READY = 1'b1;
    @(posedge clk);
    #1 dif.RESULT_READY = 1'b0;
    @(negedge clk);
    check("idle_after_ack", {31'd0, dif.READY}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int lat;
    bit busy_seen;
    int exp_lat;
    exp_lat = ref_latency(op, a, b);
    issue(op, a, b, rd);
    wait_valid(lat, busy_seen);
    check({tag, "_result"}, dif.RESULT, ref_result(op, a, b));
    check({tag, "_rd"}, {27'd0, dif.RD_OUT}, {27'd0, rd});
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_seen"}, {31'd0, busy_seen}, {31'd0, exp_lat != 0});
    release_result();
  endtask

  initial begin
    int lat;
    bit busy_seen;
    bit valid_seen;
    logic [31:0] held_res;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int sel;

    dif.START = 1'b0; dif.OP = '0; dif.OPERAND_A = '0; dif.OPERAND_B = '0;
    dif.RD_IN = '0; dif.FLUSH = 1'b0; dif.RESULT_READY = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, dif.READY}, 32'd1);
    check("rst_busy", {31'd0, dif.BUSY}, 32'd0);
    check("rst_valid", {31'd0, dif.RESULT_VALID}, 32'd0);
    check("rst_result", dif.RESULT, 32'd0);
    check("rst_rd", {27'd0, dif.RD_OUT}, 32'd0);
    rst_n = 1'b1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd5);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd3);
    run_op("divu_div0", OP_DIVU, 32'd1234, 32'd0, 5'd4);
    run_op("rem_div0", OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd6);
    run_op("div_ovf", OP_DIV, INT_MIN, 32'hFFFF_FFFF, 5'd7);
    run_op("rem_ovf", OP_REM, INT_MIN, 32'hFFFF_FFFF, 5'd8);
    run_op("div_rd0", OP_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd0);

    // Back-pressure: result must hold and a new START must be ignored.
    issue(OP_DIVU, 32'd5000, 32'd9, 5'd12);
    wait_valid(lat, busy_seen);
    held_res = ref_result(OP_DIVU, 32'd5000, 32'd9);
    check("bp_result", dif.RESULT, held_res);
    for (int i = 0; i < 10; i++) begin
      dif.START = 1'b1; dif.OP = OP_DIVU; dif.OPERAND_A = 32'd77;
      dif.OPERAND_B = 32'd0; dif.RD_IN = 5'd30;
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_result", dif.RESULT, held_res);
      check("bp_hold_rd", {27'd0, dif.RD_OUT}, 32'd12);
      check("bp_hold_ready", {31'd0, dif.READY}, 32'd0);
    end
    dif.START = 1'b0;
    release_result();
    check("bp_valid_drop", {31'd0, dif.RESULT_VALID}, 32'd0);
    run_op("bp_next", OP_REMU, 32'd5000, 32'd9, 5'd13);

    // Flush at iteration 10.
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, 5'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    dif.FLUSH = 1'b1;
    @(posedge clk);
    #1 dif.FLUSH = 1'b0;
    @(negedge clk);
    check("flush_ready", {31'd0, dif.READY}, 32'd1);
    check("flush_valid", {31'd0, dif.RESULT_VALID}, 32'd0);
    valid_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      valid_seen |= dif.RESULT_VALID;
    end
    check("flush_no_valid", {31'd0, valid_seen}, 32'd0);

    // Asynchronous reset at iteration 20.
    issue(OP_DIV, 32'h1234_5678, 32'd11, 5'd21);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, dif.READY}, 32'd1);
    check("arst_busy", {31'd0, dif.BUSY}, 32'd0);
    check("arst_valid", {31'd0, dif.RESULT_VALID}, 32'd0);
    check("arst_result", dif.RESULT, 32'd0);
    check("arst_rd", {27'd0, dif.RD_OUT}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      rb = 32'd0;
      else if (sel == 1) begin rb = 32'hFFFF_FFFF; ra = INT_MIN; end
      else if (sel == 2) rb = $urandom_range(1, 15);
      else if (sel == 3) rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
      else               rb = $urandom >> $urandom_range(0, 31);
      run_op("rand", rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
